// File: rtl/bean_tracker_if.sv
// Bus between the game-logic driver and the bean tracker: player/ghost positions in,
// bean grid, score and end-of-game status out.
interface bean_tracker_if;
  logic          start;
  logic          tick;
  logic [9:0]    pac_x;
  logic [8:0]    pac_y;
  logic [9:0]    ghost_x [4];
  logic [8:0]    ghost_y [4];
  logic [1199:0] beanmap;
  logic [15:0]   score;
  logic [10:0]   beans_left;
  logic          eat;
  logic          over;
  logic          win;

  modport master (
    output start, tick, pac_x, pac_y, ghost_x, ghost_y,
    input  beanmap, score, beans_left, eat, over, win
  );

  modport slave (
    input  start, tick, pac_x, pac_y, ghost_x, ghost_y,
    output beanmap, score, beans_left, eat, over, win
  );
endinterface

// File: rtl/bean_tracker.sv
// Owns the 40x30 bean grid and game-end state: counts beans on level load, clears the
// bean under Pac-Man's centre each tick, tracks score and detects ghost contact.
module bean_tracker #(
  parameter logic [1199:0] INIT_MAP  = {30{1'b0, {38{1'b1}}, 1'b0}},
  parameter int            BEAN_PTS  = 10,
  parameter int            COLL_DIST = 24
) (
  input  logic          clk,
  input  logic          rst,
  bean_tracker_if.slave bus
);

  localparam logic [10:0] LAST_IDX = 11'd1199;
  localparam logic [9:0]  COLL_W   = 10'(COLL_DIST);
  localparam logic [16:0] PTS_W    = 17'(BEAN_PTS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    WIN  = 3'd3,
    DEAD = 3'd4
  } state_t;

  // Unsigned distance test on one axis; y coordinates are zero-extended by the caller.
  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d < COLL_W;
  endfunction

  state_t        state_r;
  logic [1199:0] beanmap_r;
  logic [15:0]   score_r;
  logic [10:0]   beans_left_r;
  logic [10:0]   scan_cnt_r;
  logic          eat_r;
  logic          over_r;
  logic          win_r;

  logic [6:0]    col_s;
  logic [5:0]    row_s;
  logic [10:0]   idx_s;
  logic          valid_s;
  logic          bean_here_s;
  logic          ghost_hit_s;
  logic [16:0]   sum_s;
  logic [15:0]   score_inc_s;
  logic [10:0]   load_sum_s;

  // Tile under the sprite centre (sprite is 32x32, so centre = top-left + 16).
  assign col_s       = 7'(({1'b0, bus.pac_x} + 11'd16) >> 4);
  assign row_s       = 6'(({1'b0, bus.pac_y} + 10'd16) >> 4);
  assign idx_s       = ({5'd0, row_s} * 11'd40) + {4'd0, col_s};
  assign valid_s     = (col_s < 7'd40) && (row_s < 6'd30);
  assign bean_here_s = valid_s && beanmap_r[valid_s ? idx_s : 11'd0];
  assign sum_s       = {1'b0, score_r} + PTS_W;
  assign score_inc_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];
  assign load_sum_s  = beans_left_r + {10'd0, INIT_MAP[scan_cnt_r]};

  // Any of the four ghosts overlapping Pac-Man on both axes.
  always_comb begin
    ghost_hit_s = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ghost_hit_s = ghost_hit_s |
                    (near(bus.pac_x, bus.ghost_x[g]) &
                     near({1'b0, bus.pac_y}, {1'b0, bus.ghost_y[g]}));
    end
  end

  // Game state machine together with the grid, score and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      beanmap_r    <= INIT_MAP;
      score_r      <= 16'd0;
      beans_left_r <= 11'd0;
      scan_cnt_r   <= 11'd0;
      eat_r        <= 1'b0;
      over_r       <= 1'b0;
      win_r        <= 1'b0;
    end else begin
      eat_r <= 1'b0;
      if (bus.start) begin
        state_r      <= LOAD;
        beanmap_r    <= INIT_MAP;
        score_r      <= 16'd0;
        beans_left_r <= 11'd0;
        scan_cnt_r   <= 11'd0;
        over_r       <= 1'b0;
        win_r        <= 1'b0;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          LOAD: begin
            beans_left_r <= load_sum_s;
            if (scan_cnt_r == LAST_IDX) begin
              // An empty layout is an immediate win.
              if (load_sum_s == 11'd0) begin
                state_r <= WIN;
                over_r  <= 1'b1;
                win_r   <= 1'b1;
              end else begin
                state_r <= PLAY;
              end
            end else begin
              scan_cnt_r <= scan_cnt_r + 11'd1;
            end
          end
          PLAY: begin
            if (bus.tick) begin
              // Ghost contact wins over eating: the bean stays on a fatal tick.
              if (ghost_hit_s) begin
                state_r <= DEAD;
                over_r  <= 1'b1;
              end else if (bean_here_s) begin
                beanmap_r[idx_s] <= 1'b0;
                score_r          <= score_inc_s;
                eat_r            <= 1'b1;
                if (beans_left_r != 11'd0) begin
                  beans_left_r <= beans_left_r - 11'd1;
                end
                if (beans_left_r == 11'd1) begin
                  state_r <= WIN;
                  over_r  <= 1'b1;
                  win_r   <= 1'b1;
                end
              end
            end
          end
          WIN:  state_r <= WIN;
          DEAD: state_r <= DEAD;
          default: begin
            state_r <= IDLE;
            over_r  <= 1'b0;
            win_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.beanmap    = beanmap_r;
  assign bus.score      = score_r;
  assign bus.beans_left = beans_left_r;
  assign bus.eat        = eat_r;
  assign bus.over       = over_r;
  assign bus.win        = win_r;

endmodule
